// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
//
// Bytes pushed over a valid/ready handshake are serialised LSB-first onto an
// idle-high line. Queued bytes are sent back-to-back with no idle gap between
// frames: the stop bit of one frame runs straight into the start bit of the next.
//
// Optional build macro UART_TX_PARITY_EN: when defined, an even-parity bit
// (XOR of the 8 data bits) is inserted between the data and stop bits (8E1).
// When undefined, the frame is plain 8N1 and no parity logic exists.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bits/s; CLK_FREQ / BAUD must be in 2..65535
//   FIFO_DEPTH  input FIFO entries; power of two, minimum 2
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_tx_data   byte offered by the producer
//   i_tx_valid  producer offers i_tx_data this cycle
//   o_tx_ready  FIFO not full; a byte is taken when valid && ready
//   o_tx_out    registered serial line, idle high
//   o_tx_busy   FSM not idle or FIFO not empty

module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_out,
  output logic       o_tx_busy
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam logic [15:0] CntMax     = 16'(ClksPerBit - 1);
  localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);
  localparam logic [AddrW:0] PtrOne  = (AddrW + 1)'(1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  logic           fifo_full, fifo_empty;
  logic           push, pop;
  logic [7:0]     head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  // Ready reflects current fullness only; a same-cycle pop does not open a slot.
  assign push       = i_tx_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= i_tx_data;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        cnt_done;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign cnt_done = (cnt_q == CntMax);

  // tx_d is the line level for the state being entered, so the output flop
  // changes on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = 16'd0;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end

      StStart: begin
        tx_d = 1'b0;
        if (cnt_done) begin
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StData: begin
        tx_d = shift_q[0];
        if (cnt_done) begin
          cnt_d = 16'd0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        tx_d = parity_q;
        if (cnt_done) begin
          cnt_d   = 16'd0;
          state_d = StStop;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif

      StStop: begin
        tx_d = 1'b1;
        if (cnt_done) begin
          cnt_d = 16'd0;
          // Chain straight into the next frame when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

`ifdef UART_TX_PARITY_EN
  // Parity is latched at pop time because the shift register is consumed.
  always_comb begin
    parity_d = parity_q;
    if (pop) parity_d = ^head;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= 16'd0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_tx_ready = !fifo_full;
  assign o_tx_out   = tx_q;
  assign o_tx_busy  = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at CLKS_PER_BIT = 10.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.

module tb_uart_tx_fifo;

  localparam int Cpb = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FrameLen = FrameBits * Cpb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_tx_data (data),
    .i_tx_valid(valid),
    .o_tx_ready(ready),
    .o_tx_out  (tx),
    .o_tx_busy (busy)
  );

  // Line monitor: finds the start edge, samples mid-bit, collects decoded bytes.
  int         cyc = 0;
  bit         mon_act = 1'b0;
  int         pos = 0;
  int         bitn = 0;
  int         stop_bad = 0;
  logic [7:0] mon_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         st_q[$];
  logic       par_q[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1'b1;
          pos     = 0;
          st_q.push_back(cyc);
        end
      end else begin
        pos++;
        if (pos % Cpb == 4) begin
          bitn = pos / Cpb;
          if (bitn >= 1 && bitn <= 8) mon_sh[bitn-1] = tx;
`ifdef UART_TX_PARITY_EN
          else if (bitn == 9) par_q.push_back(tx);
`endif
          else if (bitn == FrameBits - 1) begin
            if (tx !== 1'b1) stop_bad++;
            rx_q.push_back(mon_sh);
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    st_q.delete();
    par_q.delete();
    stop_bad = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL idle_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", ready); end
  endtask

  // One byte into an empty FIFO; every line cycle is checked against the frame.
  task automatic test_single_frame(input logic [7:0] b);
    logic [10:0] frame;
    logic        expv;
`ifdef UART_TX_PARITY_EN
    frame = {1'b1, ^b, b, 1'b0};
`else
    frame = {1'b0, 1'b1, b, 1'b0};
`endif
    clear_mon();
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL single_ready %h: got %b want 1", b, ready); end
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_latency %h: got %b want 1", b, tx); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_push %h: got %b want 1", b, busy); end
    for (int k = 0; k < FrameLen; k++) begin
      @(negedge clk);
      expv = frame[k / Cpb];
      n_cmp++;
      if (tx !== expv) begin
        n_bad++;
        $display("FAIL single_line %h cyc %0d: got %b want %b", b, k, tx, expv);
      end
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_stop %h: got %b want 1", b, busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end %h: got %b want 0", b, busy); end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_idle %h: got %b want 1", b, tx); end
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      n_bad++;
      $display("FAIL single_decode: got %0d bytes first %h want 1 byte %h", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int         c;
    bytes[0] = 8'hA5; bytes[1] = 8'h0F; bytes[2] = 8'hFF; bytes[3] = 8'h00;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready %0d: got %b want 1", i, ready); end
      data  = bytes[i];
      valid = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    c = 0;
    while (busy && c < 600) begin @(negedge clk); c++; end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: busy %b after %0d", busy, c); end
    n_cmp++; if (rx_q.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (rx_q.size() > i) begin
        n_cmp++;
        if (rx_q[i] !== bytes[i]) begin
          n_bad++; $display("FAIL b2b_byte %0d: got %h want %h", i, rx_q[i], bytes[i]);
        end
      end
      if (i > 0 && st_q.size() > i) begin
        n_cmp++;
        if (st_q[i] - st_q[i-1] != FrameLen) begin
          n_bad++; $display("FAIL b2b_period %0d: got %0d want %0d", i, st_q[i] - st_q[i-1], FrameLen);
        end
      end
    end
    n_cmp++; if (stop_bad != 0) begin n_bad++; $display("FAIL b2b_stop: got %0d bad want 0", stop_bad); end
  endtask

  task automatic test_full();
    logic [7:0] bytes [6];
    int         idx;
    bit         will_acc;
    int         c;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
    clear_mon();
    @(negedge clk);
    idx   = 0;
    data  = bytes[0];
    valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      will_acc = valid && ready;
      @(negedge clk);
      if (will_acc) begin
        idx++;
        if (idx < 6) data = bytes[idx];
        else valid = 1'b0;
      end
    end
    n_cmp++; if (idx != 5) begin n_bad++; $display("FAIL full_accepted: got %0d want 5", idx); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", ready); end
    valid = 1'b0;
    c = 0;
    while (busy && c < 800) begin @(negedge clk); c++; end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_timeout: busy %b after %0d", busy, c); end
    n_cmp++; if (rx_q.size() != 5) begin n_bad++; $display("FAIL full_count: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (rx_q.size() > i) begin
        n_cmp++;
        if (rx_q[i] !== bytes[i]) begin
          n_bad++; $display("FAIL full_byte %0d: got %h want %h", i, rx_q[i], bytes[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    @(negedge clk);
    data  = 8'h3C;
    valid = 1'b1;
    @(negedge clk);
    data  = 8'h99;
    @(negedge clk);
    valid = 1'b0;
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rmid_start: got %b want 0", tx); end
    repeat (44) @(negedge clk);
    // Middle of data bit 3 of 0x3C, with 0x99 still queued.
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rmid_bit3: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    st_q.delete();
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rmid_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", ready); end
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rmid_quiet cyc %0d: got tx %b busy %b want 1 0", k, tx, busy);
      end
    end
    n_cmp++; if (st_q.size() != 0) begin n_bad++; $display("FAIL rmid_frames: got %0d want 0", st_q.size()); end
    n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL rmid_bytes: got %0d want 0", rx_q.size()); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int c;
    clear_mon();
    @(negedge clk);
    data  = 8'h07;
    valid = 1'b1;
    @(negedge clk);
    data  = 8'h03;
    @(negedge clk);
    valid = 1'b0;
    c = 0;
    while (busy && c < 400) begin @(negedge clk); c++; end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL par_timeout: busy %b after %0d", busy, c); end
    n_cmp++;
    if (par_q.size() != 2 || par_q[0] !== 1'b1 || par_q[1] !== 1'b0) begin
      n_bad++; $display("FAIL par_bits: got %0d bits want 1 then 0", par_q.size());
    end
    n_cmp++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h07 || rx_q[1] !== 8'h03) begin
      n_bad++; $display("FAIL par_bytes: got %0d bytes want 07 03", rx_q.size());
    end
    n_cmp++;
    if (st_q.size() != 2 || st_q[1] - st_q[0] != 110) begin
      n_bad++; $display("FAIL par_period: got %0d starts want 2 spaced 110", st_q.size());
    end
    n_cmp++; if (stop_bad != 0) begin n_bad++; $display("FAIL par_stop: got %0d bad want 0", stop_bad); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame(8'h55);
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_single_frame(8'h00);
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
